// File: rtl/fifo_uart_drain.sv
// Drains a synchronous FIFO one word at a time onto an asynchronous serial line.
// Optional even-parity bit enabled by defining FIFO_UART_DRAIN_PARITY_EN.
module fifo_uart_drain #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

`ifdef FIFO_UART_DRAIN_PARITY_EN
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
`endif

  state_t             state_reg, state_next;
  logic [BAUD_W-1:0]  baud_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic [15:0]        frame_count_reg;
  logic               bit_end;
  logic               timed;
`ifdef FIFO_UART_DRAIN_PARITY_EN
  logic               parity_reg;
`endif

  assign bit_end     = (baud_reg == BAUD_LAST);
  assign timed       = (state_reg != IDLE) && (state_reg != POP) && (state_reg != LOAD);
  assign frame_count = frame_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      baud_reg        <= '0;
      idx_reg         <= '0;
      shift_reg       <= '0;
      frame_count_reg <= '0;
`ifdef FIFO_UART_DRAIN_PARITY_EN
      parity_reg      <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;

      // Counters restart on every state entry; DATA reuses the baud counter per bit.
      if (state_next != state_reg || !timed || bit_end)
        baud_reg <= '0;
      else
        baud_reg <= baud_reg + 1'b1;

      if (state_next != state_reg)
        idx_reg <= '0;
      else if (state_reg == DATA && bit_end)
        idx_reg <= idx_reg + 1'b1;

      // FIFO read latency is one cycle, so the popped word is valid in LOAD.
      if (state_reg == LOAD) begin
        shift_reg  <= fifo_data;
`ifdef FIFO_UART_DRAIN_PARITY_EN
        parity_reg <= ^fifo_data;
`endif
      end else if (state_reg == DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
      end

      if (frame_done)
        frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    fifo_rd    = 1'b0;
    tx         = 1'b1;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (enable && !fifo_empty)
          state_next = POP;
      end
      POP: begin
        fifo_rd    = 1'b1;
        state_next = LOAD;
      end
      LOAD: state_next = START;
      START: begin
        tx = 1'b0;
        if (bit_end)
          state_next = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_end && idx_reg == IDX_LAST)
`ifdef FIFO_UART_DRAIN_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
      end
`ifdef FIFO_UART_DRAIN_PARITY_EN
      PARITY: begin
        tx = parity_reg;
        if (bit_end)
          state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: FIFO model on the read side, expected frames built
// from the start/data/parity/stop rule; a second instance runs with CLKS_PER_BIT=1.
module tb_fifo_uart_drain;

`ifdef FIFO_UART_DRAIN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CPB = 4;
  localparam int FL  = (8 + 2 + PAR) * CPB;
  localparam int FL1 = (8 + 2 + PAR);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd, tx, busy, frame_done;
  logic [15:0] frame_count;

  logic        enable1 = 1'b1;
  logic        empty1 = 1'b1;
  logic [7:0]  data1 = 8'h00;
  logic        fifo_rd1, tx1, busy1, frame_done1;
  logic [15:0] frame_count1;

  int vectors = 0;
  int errors = 0;
  int exp_count = 0;
  int cycle = 0;
  int rd_pulses = 0;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_uart_drain #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  fifo_uart_drain #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .fifo_empty(empty1),
    .fifo_data(data1), .fifo_rd(fifo_rd1), .tx(tx1), .busy(busy1),
    .frame_done(frame_done1), .frame_count(frame_count1)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency, plus an underflow watchdog.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (fifo_rd === 1'b1) begin
      rd_pulses <= rd_pulses + 1;
      fifo_data <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
      if (fifo_empty) begin
        errors <= errors + 1;
        $display("FAIL underflow: fifo_rd=1 with fifo_empty=1 at cycle %0d", cycle);
      end
    end
  end

  task automatic push(input logic [7:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr++;
  endtask

  function automatic logic [63:0] exp_frame(input logic [7:0] w, input int cpb);
    bit q[$];
    logic [63:0] f;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(w[i]);
    if (PAR == 1) q.push_back(^w);
    q.push_back(1'b1);
    f = '1;
    for (int c = 0; c < q.size() * cpb; c++) f[c] = q[c / cpb];
    return f;
  endfunction

  // Observes one frame: waits for the pop, skips LOAD, records tx per cycle from START.
  task automatic capture(output int t_rd, output logic [63:0] obs, output int done_at,
                         output bit timeout);
    int n = 0;
    timeout = 1'b0; obs = '1; done_at = -1; t_rd = -1;
    while (fifo_rd !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin timeout = 1'b1; return; end
    t_rd = cycle;
    @(negedge clk);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      obs[i] = tx;
      if (frame_done === 1'b1 && done_at < 0) done_at = i;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    vectors++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", fifo_rd); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    vectors++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", frame_count); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single(input logic [7:0] w);
    int t; logic [63:0] obs; int d; bit to; int base;
    logic [63:0] mask;
    mask = (64'd1 << FL) - 64'd1;
    base = rd_pulses;
    enable = 1'b1;
    push(w);
    capture(t, obs, d, to);
    exp_count++;
    vectors++;
    if (to) begin errors++; $display("FAIL single_timeout: no fifo_rd for %h", w); return; end
    if ((obs & mask) !== (exp_frame(w, CPB) & mask))
      begin errors++; $display("FAIL single_frame %h: got %h want %h", w, obs & mask, exp_frame(w, CPB) & mask); end
    vectors++; if (d !== FL - 1) begin errors++; $display("FAIL single_done_pos: got %0d want %0d", d, FL - 1); end
    vectors++; if (rd_pulses - base !== 1) begin errors++; $display("FAIL single_rd_pulses: got %0d want 1", rd_pulses - base); end
    vectors++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL single_count: got %0d want %0d", frame_count, exp_count); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    $display("single word %h: frame checked, frame_count=%0d", w, frame_count);
  endtask

  task automatic test_empty;
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if ({fifo_rd, tx, busy} !== 3'b010)
        begin errors++; $display("FAIL empty_idle cyc %0d: rd/tx/busy got %b want 010", i, {fifo_rd, tx, busy}); end
    end
    $display("empty FIFO: 100 idle cycles checked");
  endtask

  task automatic test_back_to_back(input int n_words, input bit randomize_words);
    logic [7:0] words [$];
    logic [63:0] obs; logic [63:0] mask; int t; int t_prev; int d; bit to; int base;
    mask = (64'd1 << FL) - 64'd1;
    base = rd_pulses;
    enable = 1'b0;
    for (int i = 0; i < n_words; i++) begin
      if (randomize_words) words.push_back(8'($urandom_range(0, 255)));
      else if (i == 0) words.push_back(8'h01);
      else if (i == 1) words.push_back(8'hFF);
      else words.push_back(8'h3C);
      push(words[i]);
    end
    enable = 1'b1;
    t_prev = -1;
    for (int i = 0; i < n_words; i++) begin
      capture(t, obs, d, to);
      exp_count++;
      vectors++;
      if (to) begin errors++; $display("FAIL b2b_timeout word %0d", i); return; end
      if ((obs & mask) !== (exp_frame(words[i], CPB) & mask))
        begin errors++; $display("FAIL b2b_frame %0d (%h): got %h want %h", i, words[i], obs & mask, exp_frame(words[i], CPB) & mask); end
      if (t_prev >= 0) begin
        vectors++;
        if (t - t_prev !== FL + 3) begin errors++; $display("FAIL b2b_interval %0d: got %0d want %0d", i, t - t_prev, FL + 3); end
      end
      $display("b2b word %0d = %h popped at cycle %0d", i, words[i], t);
      t_prev = t;
    end
    vectors++; if (rd_pulses - base !== n_words) begin errors++; $display("FAIL b2b_rd_pulses: got %0d want %0d", rd_pulses - base, n_words); end
    vectors++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", frame_count, exp_count); end
  endtask

  task automatic test_enable_drop;
    logic [7:0] w1, w2; logic [63:0] obs; logic [63:0] mask; int t; int d; bit to; int base;
    mask = (64'd1 << FL) - 64'd1;
    w1 = 8'($urandom_range(0, 255));
    w2 = 8'($urandom_range(0, 255));
    base = rd_pulses;
    enable = 1'b1;
    push(w1);
    push(w2);
    fork
      capture(t, obs, d, to);
      begin repeat (20) @(negedge clk); enable = 1'b0; end
    join
    exp_count++;
    vectors++;
    if (to) begin errors++; $display("FAIL drop_timeout"); return; end
    if ((obs & mask) !== (exp_frame(w1, CPB) & mask))
      begin errors++; $display("FAIL drop_frame1: got %h want %h", obs & mask, exp_frame(w1, CPB) & mask); end
    repeat (60) @(negedge clk);
    vectors++; if (rd_pulses - base !== 1) begin errors++; $display("FAIL drop_rd_pulses: got %0d want 1", rd_pulses - base); end
    vectors++; if (frame_count !== 16'(exp_count)) begin errors++; $display("FAIL drop_count: got %0d want %0d", frame_count, exp_count); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
    $display("enable drop: word %h sent, word %h held", w1, w2);
    enable = 1'b1;
    capture(t, obs, d, to);
    exp_count++;
    vectors++;
    if (to) begin errors++; $display("FAIL drop_resume_timeout"); return; end
    if ((obs & mask) !== (exp_frame(w2, CPB) & mask))
      begin errors++; $display("FAIL drop_frame2: got %h want %h", obs & mask, exp_frame(w2, CPB) & mask); end
  endtask

`ifdef FIFO_UART_DRAIN_PARITY_EN
  task automatic test_parity(input logic [7:0] w);
    logic [63:0] obs; int t; int d; bit to;
    enable = 1'b1;
    push(w);
    capture(t, obs, d, to);
    exp_count++;
    vectors++;
    if (to) begin errors++; $display("FAIL parity_timeout %h", w); return; end
    if (obs[9 * CPB + 1] !== ^w) begin errors++; $display("FAIL parity_bit %h: got %b want %b", w, obs[9 * CPB + 1], ^w); end
    vectors++; if (d + 1 !== 44) begin errors++; $display("FAIL parity_len %h: got %0d want 44", w, d + 1); end
    $display("parity word %h: parity bit %b, length %0d", w, obs[9 * CPB + 1], d + 1);
  endtask
`endif

  task automatic test_cpb1;
    logic [63:0] obs; logic [63:0] mask; int n; int d;
    mask = (64'd1 << FL1) - 64'd1;
    obs = '1; d = -1; n = 0;
    data1 = 8'h07;
    empty1 = 1'b0;
    while (fifo_rd1 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    empty1 = 1'b1;
    vectors++;
    if (n >= 50) begin errors++; $display("FAIL cpb1_timeout"); return; end
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i < 64) obs[i] = tx1;
      if (frame_done1 === 1'b1 && d < 0) d = i;
    end
    if (d + 1 !== FL1) begin errors++; $display("FAIL cpb1_len: got %0d want %0d", d + 1, FL1); end
    vectors++;
    if ((obs & mask) !== (exp_frame(8'h07, 1) & mask))
      begin errors++; $display("FAIL cpb1_frame: got %h want %h", obs & mask, exp_frame(8'h07, 1) & mask); end
    vectors++; if (frame_count1 !== 16'd1) begin errors++; $display("FAIL cpb1_count: got %0d want 1", frame_count1); end
    $display("cpb1 word 07: frame length %0d", d + 1);
  endtask

  task automatic test_reset_mid;
    int n = 0; int base;
    enable = 1'b1;
    push(8'h00);
    while (fifo_rd !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 50) begin errors++; $display("FAIL midreset_timeout"); return; end
    repeat (1 + CPB + 6) @(negedge clk);
    if (tx !== 1'b0) begin errors++; $display("FAIL midreset_pre_tx: got %b want 0", tx); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    vectors++; if (frame_count !== 16'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", frame_count); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
    base = rd_pulses;
    repeat (60) @(negedge clk);
    vectors++; if (rd_pulses !== base) begin errors++; $display("FAIL midreset_no_pop: got %0d pops want 0", rd_pulses - base); end
    vectors++; if ({tx, busy, frame_count} !== {1'b1, 1'b0, 16'd0})
      begin errors++; $display("FAIL midreset_idle: tx=%b busy=%b count=%0d want 1 0 0", tx, busy, frame_count); end
    $display("mid-frame reset: frame aborted, line idle");
  endtask

  initial begin
    test_reset;
    test_single(8'hA5);
    test_empty;
    test_back_to_back(3, 1'b0);
    test_back_to_back(6, 1'b1);
    test_enable_drop;
`ifdef FIFO_UART_DRAIN_PARITY_EN
    test_parity(8'hA5);
    test_parity(8'h07);
`endif
    test_cpb1;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_uart_drain.md
# fifo_uart_drain

Downstream consumer of `sync_fifo`: pops one word at a time when the FIFO is non-empty and transmits it as an asynchronous serial frame on `tx`. The frame is a start bit, data LSB-first, an optional even-parity bit, and a stop bit. The block connects directly to the FIFO's `read`, `data_out` and `fifo_empty` pins and owns the FIFO's read side.

## Interface
- `WIDTH`, default 8: data word width; equals the FIFO's `FIFO_WIDTH`.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range ≥1.

- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `enable` input, 1 bit: permits starting new frames.
- `fifo_empty` input, 1 bit: from FIFO.
- `fifo_data` input, `WIDTH` bits: FIFO `data_out`.
- `fifo_rd` output, 1 bit: FIFO `read`; single-cycle pop strobe.
- `tx` output, 1 bit: serial line; idle high.
- `busy` output, 1 bit: high in every state except IDLE.
- `frame_done` output, 1 bit: one-cycle pulse at the end of a stop bit.
- `frame_count` output, 16 bits: completed frames; wraps from 16'hFFFF to 0.

## Operation
- Reset (reset=0, asynchronous) drives: `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0, `frame_count`=0, state=IDLE, shift register cleared.
- States and transitions:
  - IDLE → POP when `enable`=1 and `fifo_empty`=0.
  - POP → LOAD after 1 cycle. `fifo_rd`=1 in POP only.
  - LOAD → START after 1 cycle. `fifo_data` is captured into the shift register in this cycle (FIFO read latency is 1 cycle).
  - START → DATA after `CLKS_PER_BIT` cycles, with `tx`=0.
  - DATA → PARITY or STOP after `WIDTH` × `CLKS_PER_BIT` cycles.
    - `tx` = shift[0]; the register shifts right at the end of each bit period.
  - PARITY → STOP after `CLKS_PER_BIT` cycles, with `tx` = XOR of the captured word (even parity).
  - STOP → IDLE after `CLKS_PER_BIT` cycles, with `tx`=1. `frame_done` pulses and `frame_count` increments in the last STOP cycle.
- Internal counters:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, minimum 1 bit, counting 0..`CLKS_PER_BIT`-1.
  - Bit index: `$clog2(WIDTH)` bits, minimum 1 bit.
  - Both counters clear on every state entry.
- `enable` is sampled only in IDLE. Deasserting it mid-frame lets the current frame complete; no further pop follows.
- `fifo_empty` is sampled only in IDLE. Its changes during a frame are ignored.
- `fifo_rd` is never asserted while `fifo_empty`=1 at the sampling edge. This prevents FIFO underflow.
- Reset mid-frame: the frame is aborted, `tx` returns high immediately, and the popped word is discarded. `frame_count` is cleared.

## Timing
- Edge at which IDLE sees `enable`=1 and `fifo_empty`=0 → `fifo_rd` high the next cycle, for exactly 1 cycle.
- `tx` falls 2 cycles after `fifo_rd` rises.
- Frame duration on `tx`: (`WIDTH`+2) × `CLKS_PER_BIT` cycles, plus `CLKS_PER_BIT` with parity.
- Back-to-back frames: the pop-to-pop interval is 3 + frame duration cycles (IDLE, POP, LOAD plus the frame). The line stays high for 3 cycles between stop bit and next start bit.
- `frame_done` and the `frame_count` increment occur in the same cycle. `busy` falls on the following edge.

## Configuration
- `FIFO_UART_DRAIN_PARITY_EN`:
  - Defined: the PARITY state is compiled in, and one even-parity bit is sent between the data bits and the stop bit.
  - Undefined: the PARITY state and its logic are absent, and DATA → STOP directly.

## Test plan
All scenarios use `WIDTH`=8 and `CLKS_PER_BIT`=4 unless noted.
- Reset: hold reset=0 for 2 cycles → `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0, `frame_count`=0.
  - Assert reset=0 mid-DATA → `tx`=1 asynchronously and `busy`=0.
- Single word 8'hA5 with parity off → `fifo_rd` is one 1-cycle pulse. `tx` bits are 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles). Then one `frame_done` pulse and `frame_count`=1.
- Three words 8'h01, 8'hFF, 8'h3C preloaded, `enable`=1 → exactly 3 `fifo_rd` pulses, spaced 43 cycles apart. The three frames match the data LSB-first, and `frame_count`=3.
- `fifo_empty`=1 with `enable`=1 for 100 cycles → `fifo_rd` never asserts, `tx`=1, `busy`=0.
- Drop `enable` during the DATA state of word 1 with 2 words queued → frame 1 completes, no second `fifo_rd`, `frame_count`=1.
- With `FIFO_UART_DRAIN_PARITY_EN` defined:
  - 8'hA5 → parity bit 0, 44-cycle frame.
  - 8'h07 → parity bit 1.
  - `CLKS_PER_BIT`=1 and 8'h07 → 11-cycle frame.
